seq_detector_prog: RTL and testbench
====================================

// Module: seq_detector_prog
// PURPOSE
//  Runtime-programmable serial bit-pattern detector, the parametrised successor to the fixed 1101 Moore detector.
//  Samples one bit per enabled clock and compares the last cfg_len bits against a programmed pattern.
//  Supports overlapping and non-overlapping match modes, a registered (Moore-style) match pulse and a saturating match counter.
//  Sits on serial/framing paths where sync words change per protocol without an RTL change.
// PARAMETERS
//  MAX_LEN      8             maximum pattern length in bits (>=2)
//  CNT_W        16            match counter width
//  RST_PATTERN  8'b0000_1101  pattern after reset (low RST_LEN bits used)
//  RST_LEN      4             pattern length after reset (1..MAX_LEN)
//  RST_OVERLAP  1             overlap mode after reset
//  localparam LEN_W = $clog2(MAX_LEN+1)
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        reset, asynchronous, active-high
//  en           in   1        sample strobe; in is consumed only when en=1
//  in           in   1        serial data bit
//  cfg_load     in   1        load cfg_pattern/cfg_len/cfg_overlap this cycle
//  cfg_pattern  in   MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
//  cfg_len      in   LEN_W    pattern length, legal 1..MAX_LEN
//  cfg_overlap  in   1        1 = matched bits may start the next match, 0 = they may not
//  clr_cnt      in   1        synchronous clear of match_cnt and cnt_sat
//  out          out  1        match pulse, registered, one cycle per match
//  match_cnt    out  CNT_W    number of matches, saturating
//  cnt_sat      out  1        sticky: match_cnt reached all-ones
//  cfg_err      out  1        one-cycle pulse: cfg_load had an illegal cfg_len
//  state_o      out  2        current FSM state, for debug
// BEHAVIOUR
//  Reset values: out=0, match_cnt=0, cnt_sat=0, cfg_err=0, state=IDLE, hist=0, fill=0; config = RST_* values.
//  History register:
//   - en=1: hist <= {hist[MAX_LEN-2:0], in}; fill <= min(fill+1, len).
//   - en=0: history and state hold; out is 0 in the following cycle.
//  Match condition (on an en edge, using the updated history): hist_next[len-1:0] == pat[len-1:0] && fill_next == len.
//  out timing:
//   - out goes 1 in the cycle after the edge that sampled the last pattern bit (latency 1 clk).
//   - out is high for exactly 1 clk.
//   - Back-to-back matches give back-to-back pulses.
//  Overlap mode after a match: fill stays at len.
//   Example: pattern 1101, in 1101101 -> 2 matches.
//  Non-overlap mode after a match: fill <= 0 and hist is cleared.
//   Example: the same stream gives 1 match; 1101 followed by 1101 gives 2.
//  FSM states and transitions:
//   - IDLE (fill=0) -> FILL on an en sample when len>1.
//   - IDLE -> ARMED on an en sample when len=1.
//   - FILL (0<fill<len) -> ARMED when fill reaches len.
//   - ARMED -> IDLE on a non-overlap match.
//   - ARMED otherwise holds.
//  cfg_load with 1<=cfg_len<=MAX_LEN:
//   - Config updates; hist and fill clear; state=IDLE.
//   - out=0 next cycle.
//   - Any en sample in the same cycle is discarded.
//   - match_cnt is unaffected.
//  cfg_load with cfg_len=0 or cfg_len>MAX_LEN: config, hist and state unchanged; cfg_err=1 for 1 clk.
//   A same-cycle en sample is still processed normally.
//  Pattern bits at or above len are ignored in the compare.
//  match_cnt:
//   - Increments in the same cycle that out rises.
//   - Holds at 2^CNT_W-1.
//   - cnt_sat sets when the count reaches all-ones and stays set until clr_cnt or rst.
//  clr_cnt coincident with a match: the counter becomes 0 (clear wins); out still pulses.
//  rst mid-stream: immediate async return to reset values, including reload of the RST_* config.
// STRUCTURE
//  Shared package seq_det_pkg:
//   - state encoding IDLE=2'd0, FILL=2'd1, ARMED=2'd2 (2'd3 illegal, decodes to IDLE)
//   - LEN_W helper function
//  One sub-module, sat_counter #(CNT_W): inc, clr, count, sat.
//  Top level holds the config registers, the history/fill logic, the FSM and the out register.
// TESTING
//  1. Default config, in=1101 with en=1 every cycle -> out=1 exactly one clk after the 4th bit; match_cnt=1.
//  2. Overlap=1, stream 1101101 -> 2 pulses 3 clks apart.
//     Reload with overlap=0, same stream -> 1 pulse.
//  3. cfg_load pattern=8'b10110011, len=8; send the pattern with en gaps inserted -> single pulse after the last en sample.
//     cfg_len=9 -> cfg_err pulse and config unchanged.
//  4. len=1, pattern=1, in=1 for 5 en cycles -> 5 consecutive out pulses; match_cnt=5.
//  5. CNT_W=3: 8 matches -> match_cnt=7, cnt_sat=1; clr_cnt together with a match -> match_cnt=0, out=1.
//  6. Assert rst after 1,1,0 -> out=0, state=IDLE; the stream must restart, so a following 1 gives no match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable sequence detector.
//   state_t     : detector FSM encoding (2'd3 is unused and decodes as IDLE)
//   calc_len_w  : width needed to hold a pattern length of 0..max_len
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no bits collected since the last restart
    ST_FILL  = 2'd1,  // some, but fewer than len, bits collected
    ST_ARMED = 2'd2   // a full window is present; every sample is a candidate match
  } state_t;

  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   inc   : count one event this cycle
//   clr   : synchronous clear of count and sat (wins over inc)
//   count : current count, holds at all-ones
//   sat   : set when count reaches all-ones, held until clr or rst
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_inc;
  logic             at_max;

  assign count_inc = count + CNT_W'(1);
  assign at_max    = &count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && !at_max) begin
      count <= count_inc;
      // The increment that lands on all-ones is the one that saturates.
      if (&count_inc) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector.
// Shifts in one bit per enabled cycle and flags when the last len bits equal
// the programmed pattern (pattern bit [len-1] is the oldest bit).
//
// Handshake note: there is no backpressure. A sample is taken on every
// rising edge where en=1; a legal cfg_load in the same cycle takes priority
// and the sample is dropped. Outputs are registered and valid every cycle.
//
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   en, in       : sample strobe and serial data bit
//   cfg_load     : load cfg_pattern / cfg_len / cfg_overlap this cycle
//   cfg_pattern  : pattern, bit [len-1] first received
//   cfg_len      : pattern length, legal 1..MAX_LEN
//   cfg_overlap  : 1 = bits of a match may start the next one
//   clr_cnt      : synchronous clear of match_cnt and cnt_sat
//   out          : one-cycle registered match pulse
//   match_cnt    : saturating match count
//   cnt_sat      : sticky, match_cnt reached all-ones
//   cfg_err      : one-cycle pulse, cfg_load carried an illegal length
//   state_o      : FSM state for debug
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1101,
  parameter int                 RST_LEN     = 4,
  parameter bit                 RST_OVERLAP = 1'b1,
  localparam int                LEN_W       = calc_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_cnt,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat,
  output logic               cfg_err,
  output logic [1:0]         state_o
);

  // Configuration registers
  logic [MAX_LEN-1:0] pat_q, pat_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic               ovl_q, ovl_n;

  // History window and number of valid bits in it (capped at len)
  logic [MAX_LEN-1:0] hist_q, hist_n;
  logic [LEN_W-1:0]   fill_q, fill_n;

  state_t             state_q, state_n;

  logic               out_n;
  logic               cfg_err_n;

  // Combinational helpers
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic               cfg_len_ok;
  logic               window_full;
  logic               hit;
  logic               restart;

  assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  // Only the low len bits of the window take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  assign hist_shift  = {hist_q[MAX_LEN-2:0], in};
  assign fill_inc    = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
  assign window_full = (fill_inc == len_q);
  assign hit         = window_full && (((hist_shift ^ pat_q) & mask) == '0);
  // A non-overlapping match consumes its bits: the next match starts fresh.
  assign restart     = hit && !ovl_q;

  always_comb begin
    pat_n     = pat_q;
    len_n     = len_q;
    ovl_n     = ovl_q;
    hist_n    = hist_q;
    fill_n    = fill_q;
    state_n   = state_q;
    out_n     = 1'b0;
    cfg_err_n = cfg_load && !cfg_len_ok;

    if (cfg_load && cfg_len_ok) begin
      // New configuration: discard any partial window and this cycle's sample.
      pat_n   = cfg_pattern;
      len_n   = cfg_len;
      ovl_n   = cfg_overlap;
      hist_n  = '0;
      fill_n  = '0;
      state_n = ST_IDLE;
    end else if (en) begin
      out_n = hit;
      if (restart) begin
        hist_n = '0;
        fill_n = '0;
      end else begin
        hist_n = hist_shift;
        fill_n = fill_inc;
      end

      case (state_q)
        ST_ARMED: state_n = restart ? ST_IDLE : ST_ARMED;
        // IDLE, FILL and the unused encoding all advance the same way;
        // with len=1 the first sample goes straight to ARMED.
        default: begin
          if (window_full) begin
            state_n = restart ? ST_IDLE : ST_ARMED;
          end else begin
            state_n = ST_FILL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q   <= RST_PATTERN;
      len_q   <= LEN_W'(RST_LEN);
      ovl_q   <= RST_OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= ST_IDLE;
      out     <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      pat_q   <= pat_n;
      len_q   <= len_n;
      ovl_q   <= ovl_n;
      hist_q  <= hist_n;
      fill_q  <= fill_n;
      state_q <= state_n;
      out     <= out_n;
      cfg_err <= cfg_err_n;
    end
  end

  assign state_o = state_q;

  // The count advances on the same edge that raises out.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_n),
    .clr   (clr_cnt),
    .count (match_cnt),
    .sat   (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_prog.sv
module tb_seq_detector_prog;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       clr_cnt = 1'b0;

  // Default-width instance
  logic        out_a, sat_a, err_a;
  logic [15:0] cnt_a;
  logic [1:0]  st_a;
  // Narrow-counter instance, same stimulus
  logic        out_b, sat_b, err_b;
  logic [2:0]  cnt_b;
  logic [1:0]  st_b;

  seq_detector_prog dut (
    .clk(clk), .rst(rst), .en(en), .in(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_cnt(clr_cnt), .out(out_a), .match_cnt(cnt_a), .cnt_sat(sat_a),
    .cfg_err(err_a), .state_o(st_a)
  );

  seq_detector_prog #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .en(en), .in(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_cnt(clr_cnt), .out(out_b), .match_cnt(cnt_b), .cnt_sat(sat_b),
    .cfg_err(err_b), .state_o(st_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bits received since the last restart, oldest first, at most len kept.
  bit         bq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         e_out, e_err;
  int         e_cnt16, e_cnt3;
  bit         e_sat16, e_sat3;

  function automatic int exp_state();
    if (bq.size() == 0) return 0;
    if (bq.size() < m_len) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    bq.delete();
    m_pat = 8'b0000_1101; m_len = 4; m_ovl = 1'b1;
    e_out = 0; e_err = 0;
    e_cnt16 = 0; e_cnt3 = 0; e_sat16 = 0; e_sat3 = 0;
  endtask

  task automatic model_step();
    bit hit = 0;
    bit ok  = cfg_load && (cfg_len >= 1) && (cfg_len <= 8);
    e_err = cfg_load && !ok;
    if (ok) begin
      m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
      bq.delete();
    end else if (en) begin
      bq.push_back(din);
      if (bq.size() > m_len) void'(bq.pop_front());
      if (bq.size() == m_len) begin
        hit = 1;
        for (int i = 0; i < m_len; i++)
          if (bq[i] != m_pat[m_len-1-i]) hit = 0;
      end
      if (hit && !m_ovl) bq.delete();
    end
    e_out = hit;
    if (clr_cnt) begin
      e_cnt16 = 0; e_cnt3 = 0; e_sat16 = 0; e_sat3 = 0;
    end else if (hit) begin
      if (e_cnt16 < 65535) e_cnt16++;
      if (e_cnt16 == 65535) e_sat16 = 1;
      if (e_cnt3 < 7) e_cnt3++;
      if (e_cnt3 == 7) e_sat3 = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Compare process: outputs are settled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("out",       out_a, e_out);
      check("state",     st_a,  exp_state());
      check("cfg_err",   err_a, e_err);
      check("match_cnt", cnt_a, e_cnt16);
      check("cnt_sat",   sat_a, e_sat16);
      check("out_s",     out_b, e_out);
      check("cnt_s",     cnt_b, e_cnt3);
      check("sat_s",     sat_b, e_sat3);
    end
  end

  // Pulse counter sampled just after each active edge.
  int pulses = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (out_a) pulses++;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit e, input bit b, input bit ld, input bit clr);
    @(negedge clk);
    en = e; din = b; cfg_load = ld; clr_cnt = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic send_bits(input string s);
    for (int i = 0; i < s.len(); i++) step(1, s[i] == 8'h31, 0, 0);
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input bit o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    step(0, 0, 1, 0);
  endtask

  int p0;

  // ---------------- directed tests ----------------
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_out", out_a, 0);
    check("rst_state", st_a, 0);
    check("rst_cnt", cnt_a, 0);

    // 1: default config 1101, latency one clock
    p0 = pulses;
    send_bits("1101");
    @(negedge clk);
    check("t1_latency", out_a, 1);
    en = 0; din = 0;
    idle(2);
    check("t1_pulses", pulses - p0, 1);
    check("t1_cnt", cnt_a, 1);

    // 2: overlap vs non-overlap
    load_cfg(8'b0000_1101, 4, 1);
    p0 = pulses;
    send_bits("1101101"); idle(2);
    check("t2_ovl_pulses", pulses - p0, 2);
    load_cfg(8'b0000_1101, 4, 0);
    p0 = pulses;
    send_bits("1101101"); idle(2);
    check("t2_novl_pulses", pulses - p0, 1);
    p0 = pulses;
    send_bits("11011101"); idle(2);
    check("t2_novl_pair", pulses - p0, 2);
    check("t2_cnt", cnt_a, 6);

    // 3: 8-bit pattern with en gaps, then illegal lengths
    load_cfg(8'b1011_0011, 8, 0);
    p0 = pulses;
    begin
      string s = "10110011";
      for (int i = 0; i < 8; i++) begin
        step(1, s[i] == 8'h31, 0, 0);
        idle($urandom_range(0, 2));
      end
    end
    idle(2);
    check("t3_pulses", pulses - p0, 1);
    cfg_pattern = 8'hFF; cfg_len = 9; cfg_overlap = 1;
    step(0, 0, 1, 0);
    @(negedge clk);
    check("t3_err9", err_a, 1);
    en = 0; cfg_load = 0;
    // length 0 together with the first sample: the sample must still count
    cfg_len = 0;
    p0 = pulses;
    step(1, 1, 1, 0);
    @(negedge clk);
    check("t3_err0", err_a, 1);
    en = 1; din = 0; cfg_load = 0;
    send_bits("110011"); idle(2);
    check("t3_pulses_kept", pulses - p0, 1);
    check("t3_cnt", cnt_a, 8);
    check("t3_cnt_s", cnt_b, 7);
    check("t3_sat_s", sat_b, 1);

    // 4: high pattern bits ignored, then len=1
    step(0, 0, 0, 1);
    load_cfg(8'b1111_0101, 3, 0);
    p0 = pulses;
    send_bits("101"); idle(2);
    check("t4_len3_pulses", pulses - p0, 1);
    step(0, 0, 0, 1);
    load_cfg(8'b0000_0001, 1, 1);
    p0 = pulses;
    send_bits("11111"); idle(2);
    check("t4_len1_pulses", pulses - p0, 5);
    check("t4_cnt", cnt_a, 5);

    // 5: saturation and clear-wins
    send_bits("11111111"); idle(1);
    check("t5_cnt", cnt_a, 13);
    check("t5_cnt_s", cnt_b, 7);
    check("t5_sat_s", sat_b, 1);
    step(1, 1, 0, 1);
    @(negedge clk);
    check("t5_clr_out", out_a, 1);
    check("t5_clr_cnt", cnt_a, 0);
    check("t5_clr_cnt_s", cnt_b, 0);
    check("t5_clr_sat_s", sat_b, 0);
    en = 0; din = 0; clr_cnt = 0;

    // 6: reset mid-stream reloads the reset config
    load_cfg(8'b0000_0110, 4, 1);
    send_bits("110");
    @(negedge clk);
    en = 0; din = 0;
    #2 rst = 1'b1;
    @(negedge clk);
    check("t6_rst_out", out_a, 0);
    check("t6_rst_state", st_a, 0);
    rst = 1'b0;
    p0 = pulses;
    send_bits("1"); idle(2);
    check("t6_no_match", pulses - p0, 0);
    send_bits("101"); idle(2);
    check("t6_reload", pulses - p0, 1);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
